// File: rtl/seq_detect_param_if.sv
// Serial sample/match bundle for the parametrised pattern detector.
// Master drives the stream and controls; slave returns match status.
interface seq_detect_param_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             inp;
    logic             overlap;
    logic             clr_cnt;
    logic             outp;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en,
        output inp,
        output overlap,
        output clr_cnt,
        input  outp,
        input  match_cnt
    );

    modport slave (
        input  en,
        input  inp,
        input  overlap,
        input  clr_cnt,
        output outp,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with overlap control,
// sample enable and a saturating match counter.
module seq_detect_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);

    localparam int HW = LEN - 1;
    localparam int FW = $clog2(LEN);
    localparam logic [FW-1:0]    FULL = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [HW-1:0]    hist_q;
    logic [HW-1:0]    hist_d;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             outp_q;
    logic             outp_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [LEN-1:0]   cand;
    logic             hit;

    assign cand = {hist_q, bus.inp};

    // Fill gating keeps reset-zeroed history from ever matching.
    assign hit = bus.en
               && (cand == PATTERN)
               && (fill_q == FULL);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        outp_d = hit;
        cnt_d  = cnt_q;
        if (bus.en) begin
            hist_d = cand[HW-1:0];
            if (hit && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            outp_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            outp_q <= outp_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.outp      = outp_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four configurations share one stream
// and are checked against a window-over-history reference model.
module tb_seq_detect_param;

    logic clk;
    logic rst;
    logic en;
    logic inp;
    logic overlap;
    logic clr_cnt;

    int total;
    int bad;

    seq_detect_param_if #(.CNT_W(8)) if0 ();
    seq_detect_param_if #(.CNT_W(2)) if1 ();
    seq_detect_param_if #(.CNT_W(8)) if2 ();
    seq_detect_param_if #(.CNT_W(4)) if3 ();

    assign if0.en = en;
    assign if0.inp = inp;
    assign if0.overlap = overlap;
    assign if0.clr_cnt = clr_cnt;
    assign if1.en = en;
    assign if1.inp = inp;
    assign if1.overlap = overlap;
    assign if1.clr_cnt = clr_cnt;
    assign if2.en = en;
    assign if2.inp = inp;
    assign if2.overlap = overlap;
    assign if2.clr_cnt = clr_cnt;
    assign if3.en = en;
    assign if3.inp = inp;
    assign if3.overlap = overlap;
    assign if3.clr_cnt = clr_cnt;

    seq_detect_param #(
        .LEN(4), .PATTERN(4'b1101), .CNT_W(8)
    ) u0 (.clk(clk), .rst(rst), .bus(if0));

    seq_detect_param #(
        .LEN(4), .PATTERN(4'b1101), .CNT_W(2)
    ) u1 (.clk(clk), .rst(rst), .bus(if1));

    seq_detect_param #(
        .LEN(3), .PATTERN(3'b000), .CNT_W(8)
    ) u2 (.clk(clk), .rst(rst), .bus(if2));

    seq_detect_param #(
        .LEN(2), .PATTERN(2'b11), .CNT_W(4)
    ) u3 (.clk(clk), .rst(rst), .bus(if3));

    logic        outs [4];
    logic [31:0] cnts [4];

    assign outs[0] = if0.outp;
    assign outs[1] = if1.outp;
    assign outs[2] = if2.outp;
    assign outs[3] = if3.outp;
    assign cnts[0] = 32'(if0.match_cnt);
    assign cnts[1] = 32'(if1.match_cnt);
    assign cnts[2] = 32'(if2.match_cnt);
    assign cnts[3] = 32'(if3.match_cnt);

    // Reference configuration per instance
    int          LENS [4] = '{4, 4, 3, 2};
    logic [31:0] PATS [4] = '{32'hD, 32'hD, 32'h0, 32'h3};
    int          CMAX [4] = '{255, 3, 255, 15};

    // Model: every accepted bit since reset, plus the stream
    // position where each instance last consumed a match.
    bit stream[$];
    int start [4];
    int mcnt  [4];
    bit mout  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        stream.delete();
        for (int d = 0; d < 4; d++) begin
            start[d] = 0;
            mcnt[d]  = 0;
            mout[d]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit hit;
        int n;
        int sz;
        if (en) stream.push_back(inp);
        sz = stream.size();
        for (int d = 0; d < 4; d++) begin
            hit = 1'b0;
            if (en) begin
                n = sz - start[d];
                if (n >= LENS[d]) begin
                    hit = 1'b1;
                    for (int i = 0; i < LENS[d]; i++)
                        if (stream[sz-1-i] != PATS[d][i]) hit = 1'b0;
                end
                if (hit && !overlap) start[d] = sz;
            end
            mout[d] = hit;
            if (clr_cnt) mcnt[d] = 0;
            else if (hit && mcnt[d] < CMAX[d]) mcnt[d]++;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s.outp[%0d]", tag, d),
                32'(outs[d]), 32'(mout[d]));
            chk($sformatf("%s.cnt[%0d]", tag, d),
                cnts[d], 32'(mcnt[d]));
        end
    endtask

    task automatic step(input bit e, input bit b,
                        input bit ov, input bit clr);
        @(negedge clk);
        en = e;
        inp = b;
        overlap = ov;
        clr_cnt = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        clr_cnt = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic feed(input logic [31:0] bits, input int n,
                        input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0);
    endtask

    bit ov_exp [7] = '{0, 0, 0, 1, 0, 0, 1};
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [31:0] s7;
    logic [31:0] s4;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        en = 1'b0;
        inp = 1'b0;
        overlap = 1'b1;
        clr_cnt = 1'b0;
        s7 = 32'b1101101;
        s4 = 32'b1101;

        do_reset();

        // Overlapping 1101 stream
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s7[6-i], 1'b1, 1'b0);
            chk($sformatf("ovl.bit%0d", i), 32'(outs[0]),
                32'(ov_exp[i]));
        end
        chk("ovl.cnt", cnts[0], 32'd2);

        // Non-overlapping, then a further match
        do_reset();
        feed(s7, 7, 1'b0);
        chk("novl.cnt1", cnts[0], 32'd1);
        feed(s4, 4, 1'b0);
        chk("novl.outp", 32'(outs[0]), 32'd1);
        chk("novl.cnt2", cnts[0], 32'd2);

        // Enable gaps never break a pattern
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            chk("gap.quiet", 32'(outs[0]), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("gap.pre", 32'(outs[0]), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap.hit", 32'(outs[0]), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("gap.width", 32'(outs[0]), 32'd0);

        // Reset mid-pattern discards history
        do_reset();
        feed(32'b110, 3, 1'b1);
        do_reset();
        chk("rmid.cnt0", cnts[0], 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rmid.nohit", 32'(outs[0]), 32'd0);
        feed(32'b101, 3, 1'b1);
        chk("rmid.hit", 32'(outs[0]), 32'd1);
        chk("rmid.cnt", cnts[0], 32'd1);

        // Saturation on the 2-bit counter, then clear vs hit
        do_reset();
        for (int k = 0; k < 5; k++) begin
            feed(s4, 4, 1'b0);
            chk($sformatf("sat.%0d", k), cnts[1], 32'(sat_exp[k]));
        end
        feed(32'b110, 3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr.outp", 32'(outs[1]), 32'd1);
        chk("clr.cnt", cnts[1], 32'd0);

        // All-zero pattern needs a full window after reset
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("zero.nohit", 32'(outs[2]), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("zero.hit", 32'(outs[2]), 32'd1);

        // Back-to-back hits with LEN=2
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            chk("b2b.outp", 32'(outs[3]), 32'd1);
            chk("b2b.cnt", cnts[3], 32'(i));
        end

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     1'($urandom),
                     $urandom_range(0, 7) != 0 ? overlap : ~overlap,
                     $urandom_range(0, 49) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: the next generation of the fixed 4-bit "1101" detector. It watches a 1-bit serial input and raises a one-cycle registered match pulse whenever the last LEN enabled samples equal PATTERN. It supports runtime overlap/non-overlap mode, a clock-enable for gapped streams, and a saturating match counter. It sits in the sequential-circuits lab datapath between the serial stimulus source and the result/scoreboard logic.

## Interface
- LEN, 4: pattern length in bits; legal range 2..32.
- PATTERN, 4'b1101: target pattern, LEN bits wide; PATTERN[LEN-1] is the first bit received.
- CNT_W, 8: width of match_cnt; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; clears all state while low.
- en  in  1  sample enable; inp is consumed only on cycles with en=1.
- inp  in  1  serial data bit.
- overlap  in  1  1: matches may share bits with the previous match; 0: bits of a match are not reused.
- clr_cnt  in  1  synchronous clear of match_cnt.
- outp  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches since reset or clr_cnt.

## Operation
- State: hist[LEN-2:0] (last LEN-1 accepted bits, newest in bit 0); fill (0..LEN-1, accepted bits usable for the next match); outp; match_cnt.
- Reset (rst low, asynchronous): hist=0, fill=0, outp=0, match_cnt=0. Outputs hold these values until the first rising edge after rst deasserts.
- Per rising edge with en=1:
  - cand = {hist, inp}; hit = (cand == PATTERN) && (fill == LEN-1).
  - hist <= {hist[LEN-3:0], inp}. For LEN=2, hist <= inp.
  - fill: if hit && !overlap then 0; else min(fill+1, LEN-1).
  - outp <= hit.
  - match_cnt: if clr_cnt then 0; else if hit && match_cnt != 2^CNT_W-1 then +1; else hold.
- Per rising edge with en=0: hist and fill hold; outp <= 0; match_cnt is cleared if clr_cnt=1 and otherwise holds. A gap never breaks or completes a pattern.
- clr_cnt takes priority over a simultaneous hit. Count ends at 0, but outp still pulses.
- overlap is sampled every enabled edge. A change takes effect on the next hit.
- The fill qualification guarantees that reset-zeroed history never completes a pattern, including all-zero PATTERN.
- Equivalence: LEN=4, PATTERN=1101, overlap=1 reproduces the legacy detector's outp sequence for any input stream.

## Timing
- Latency: outp is high during the cycle after the rising edge that samples the final pattern bit. Pulse width is exactly one cycle per hit.
- Back-to-back hits are possible, e.g. PATTERN=11, overlap=1, continuous 1s. outp then stays high on consecutive cycles, and match_cnt increments each cycle.
- match_cnt updates on the same edge as outp.
- Reset mid-pattern discards partial history. At least LEN enabled samples are needed after rst rises before any hit.
- No combinational path from inputs to outputs.

## Test plan
- Overlap: LEN=4, PATTERN=1101, overlap=1, en=1, stream 1,1,0,1,1,0,1 -> outp high after the 4th and 7th bits; match_cnt=2.
- Non-overlap: same stream with overlap=0 -> outp high only after the 4th bit; match_cnt=1. Then append 1,1,0,1 -> one further pulse; match_cnt=2.
- Enable gaps: bits 1,1, then 3 cycles en=0 with inp=0, then 0,1 -> one pulse, one cycle after the final 1. outp stays 0 during the gap.
- Reset mid-pattern: 1,1,0, then rst low for 1 cycle, then 1 -> no pulse. Continue 1,0,1 -> pulse; counters were 0 after reset.
- Saturation/clear: CNT_W=2, 5 non-overlapping matches -> match_cnt sequence 1,2,3,3,3. Then clr_cnt on the cycle of a 6th hit -> outp=1 and match_cnt=0.
- All-zero pattern: LEN=3, PATTERN=000, from reset feed 0,0 -> no pulse. The third 0 -> pulse.
